commit_trace_src: RTL and testbench
===================================

// Module: commit_trace_src
// PURPOSE
//  Pipeline-side producer for the commit-trace interface (pc/nextpc/inst/dpi_valid) consumed by the
//  simulation DPI reporter. Captures retire events from the writeback stage into a small FIFO.
//  Presents one registered record per cycle so the reporter can sample at negedge. Checks pc/nextpc
//  chain continuity across consecutive records.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >=2
//  AW      2   pointer width = log2(DEPTH)
// PORTS
//  clock       in   1   sole clock; all state updates on posedge
//  reset       in   1   asynchronous, active-low reset
//  wb_valid    in   1   writeback stage retires an instruction this cycle
//  wb_ready    out  1   FIFO can accept a record
//  wb_pc       in   32  pc of retiring instruction
//  wb_nextpc   in   32  architectural next pc of retiring instruction
//  wb_inst     in   32  instruction word
//  out_ready   in   1   consumer accepts head record (tie 1 for DPI reporter)
//  dpi_valid   out  1   head record valid
//  pc          out  32  head pc
//  nextpc      out  32  head nextpc
//  inst        out  32  head inst
//  chain_err   out  1   sticky: a record's pc != previous record's nextpc
//  err_pc      out  32  pc of first record that broke the chain
// BEHAVIOUR
//  - Reset (reset=0, async): count=0, rd/wr ptrs=0, dpi_valid=0, pc/nextpc/inst=0, chain_err=0,
//    err_pc=0, have_last=0, last_nextpc=0, wb_ready=1 once reset released.
//  - push = wb_valid & wb_ready; pop = dpi_valid & out_ready.
//  - wb_ready = (count != DEPTH); depends on count only, NOT on same-cycle pop (no pass-through).
//  - Push writes {pc,nextpc,inst} at wr_ptr, wr_ptr+1 mod DEPTH (wraps). Pop advances rd_ptr mod DEPTH.
//  - count: +1 push only, -1 pop only, unchanged on push&pop. Never exceeds DEPTH, never underflows.
//  - Outputs pc/nextpc/inst/dpi_valid are registers loaded at posedge from the next head entry;
//    stable across a whole cycle (safe for negedge sampling). Latency wb push -> dpi_valid: 1 cycle
//    when FIFO empty; a pushed record never appears before older records.
//  - dpi_valid=0 when empty; pc/nextpc/inst hold last value (don't-care for consumer).
//  - wb_valid while full: record not accepted; upstream must hold (no drop, no overwrite).
//  - Push and pop same cycle at count=1: new record becomes head next cycle, dpi_valid stays 1.
//  - Chain check on each pop: if have_last & (pc != last_nextpc) and chain_err==0 -> chain_err=1,
//    err_pc=pc. Then last_nextpc=nextpc, have_last=1. chain_err clears only on reset.
//  - Reset mid-operation: all queued records discarded; first record after reset not chain-checked.
//  - No FSM beyond FIFO occupancy; states EMPTY(count=0)/PARTIAL/FULL(count=DEPTH) follow count.
// CONFIGURATION
//  COMMIT_CNT_EN defined: adds output port commit_cnt [63:0], reset 0, +1 on every pop, wraps at
//    2^64; updated at same posedge as pop.
//  COMMIT_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 reset low mid-stream with 3 queued -> dpi_valid=0, count=0, chain_err=0 immediately (async).
//  2 push {pc=0x80000000,nextpc=0x80000004,inst=0x00000013}, out_ready=1 -> next cycle dpi_valid=1,
//    pc=0x80000000; following cycle dpi_valid=0.
//  3 out_ready=0, 5 back-to-back pushes, DEPTH=4 -> wb_ready=0 after 4th; 5th held; release
//    out_ready -> 5 records out in push order, none lost.
//  4 chain: pops pc 0x80000000/nextpc 0x80000004 then pc 0x80000010 -> chain_err=1, err_pc=0x80000010;
//    later mismatch at 0x80000020 -> err_pc unchanged.
//  5 steady push&pop every cycle for 20 cycles at count=1 -> dpi_valid stays 1, ptrs wrap, order kept;
//    with COMMIT_CNT_EN commit_cnt=20 after last pop.

Source files
------------

// File: rtl/commit_trace_if.sv
// Commit-trace bundle: writeback retire side plus the registered head record seen by the DPI reporter.
// master = trace producer (commit_trace_src), slave = writeback stage / reporter side.
interface commit_trace_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc;
  logic [31:0] wb_nextpc;
  logic [31:0] wb_inst;
  logic        out_ready;
  logic        dpi_valid;
  logic [31:0] pc;
  logic [31:0] nextpc;
  logic [31:0] inst;
  logic        chain_err;
  logic [31:0] err_pc;

  modport master (
    input  wb_valid, wb_pc, wb_nextpc, wb_inst, out_ready,
    output wb_ready, dpi_valid, pc, nextpc, inst, chain_err, err_pc
  );

  modport slave (
    output wb_valid, wb_pc, wb_nextpc, wb_inst, out_ready,
    input  wb_ready, dpi_valid, pc, nextpc, inst, chain_err, err_pc
  );
endinterface

// File: rtl/commit_trace_src.sv
// Commit-trace producer: retire records queue in a small FIFO whose head is held in registers,
// with a sticky pc/nextpc chain-continuity check. Define COMMIT_CNT_EN to add the 64-bit commit_cnt.
module commit_trace_src #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  commit_trace_if.master trace
`ifdef COMMIT_CNT_EN
  ,
  output logic [63:0]   commit_cnt
`endif
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] inst;
  } rec_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  rec_t          mem_q [DEPTH];
  rec_t          wb_rec;
  rec_t          head_q, head_d;
  logic          dpi_valid_q, dpi_valid_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   count_after_pop;
  logic          chain_err_q, chain_err_d;
  logic [31:0]   err_pc_q, err_pc_d;
  logic          have_last_q, have_last_d;
  logic [31:0]   last_nextpc_q, last_nextpc_d;
  logic          push, pop;

  assign wb_rec = '{pc: trace.wb_pc, nextpc: trace.wb_nextpc, inst: trace.wb_inst};

  // Ready looks at occupancy only, so a full FIFO never accepts even when the head pops.
  assign trace.wb_ready = (count_q != FULL_CNT);
  assign push           = trace.wb_valid & trace.wb_ready;
  assign pop            = dpi_valid_q & trace.out_ready;

  assign trace.dpi_valid = dpi_valid_q;
  assign trace.pc        = head_q.pc;
  assign trace.nextpc    = head_q.nextpc;
  assign trace.inst      = head_q.inst;
  assign trace.chain_err = chain_err_q;
  assign trace.err_pc    = err_pc_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    head_d          = head_q;
    dpi_valid_d     = dpi_valid_q;
    chain_err_d     = chain_err_q;
    err_pc_d        = err_pc_q;
    have_last_d     = have_last_q;
    last_nextpc_d   = last_nextpc_q;
    count_after_pop = count_q - (AW+1)'(pop);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A record pushed into an otherwise empty queue becomes the head straight from the input,
    // since its memory slot is only written at this same edge.
    dpi_valid_d = (count_d != '0);
    if (push && count_after_pop == '0) begin
      head_d = wb_rec;
    end else if (count_d != '0) begin
      head_d = mem_q[rd_ptr_d];
    end

    if (pop) begin
      if (have_last_q && (head_q.pc != last_nextpc_q) && !chain_err_q) begin
        chain_err_d = 1'b1;
        err_pc_d    = head_q.pc;
      end
      last_nextpc_d = head_q.nextpc;
      have_last_d   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      head_q        <= '0;
      dpi_valid_q   <= 1'b0;
      chain_err_q   <= 1'b0;
      err_pc_q      <= '0;
      have_last_q   <= 1'b0;
      last_nextpc_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      head_q        <= head_d;
      dpi_valid_q   <= dpi_valid_d;
      chain_err_q   <= chain_err_d;
      err_pc_q      <= err_pc_d;
      have_last_q   <= have_last_d;
      last_nextpc_q <= last_nextpc_d;
    end
  end

  // NOTE: storage has no reset; an entry is never read before a push has written it.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wb_rec;
  end

`ifdef COMMIT_CNT_EN
  logic [63:0] commit_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   commit_cnt_q <= '0;
    else if (pop) commit_cnt_q <= commit_cnt_q + 64'd1;
  end

  assign commit_cnt = commit_cnt_q;
`endif

endmodule

// File: tb/tb_commit_trace_src.sv
// Scoreboard bench for commit_trace_src: a negedge monitor models occupancy, head order and the
// chain check; records are queued when the model accepts them and compared when the DUT pops them.
module tb_commit_trace_src;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] inst;
  } rec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  commit_trace_if tif ();
`ifdef COMMIT_CNT_EN
  logic [63:0] commit_cnt;
`endif

  commit_trace_src #(.DEPTH(DEPTH), .AW(2)) dut (
    .clock (clock),
    .reset (reset),
    .trace (tif)
`ifdef COMMIT_CNT_EN
    ,
    .commit_cnt (commit_cnt)
`endif
  );

  rec_t            exp_q[$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              m_count = 0;
  bit              m_pushed = 0;
  bit              m_have_last = 0;
  bit              m_err = 0;
  logic [31:0]     m_last_nextpc = '0;
  logic [31:0]     m_err_pc = '0;
  longint unsigned m_pops = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model runs on the negedge, where inputs and registered outputs are both stable.
  always @(negedge clock) begin
    bit   push, pop;
    rec_t r;
    if (!reset) begin
      exp_q.delete();
      m_count = 0; m_pushed = 0; m_have_last = 0; m_err = 0;
      m_last_nextpc = '0; m_err_pc = '0; m_pops = 0;
    end else begin
      check("wb_ready", 64'(tif.wb_ready), 64'(m_count != DEPTH));
      check("dpi_valid", 64'(tif.dpi_valid), 64'(m_count != 0));
      check("chain_err", 64'(tif.chain_err), 64'(m_err));
      check("err_pc", 64'(tif.err_pc), 64'(m_err_pc));
`ifdef COMMIT_CNT_EN
      check("commit_cnt", commit_cnt, m_pops);
`endif
      pop  = (m_count != 0) && tif.out_ready;
      push = tif.wb_valid && (m_count != DEPTH);
      if (pop) begin
        r = exp_q.pop_front();
        check("head_pc", 64'(tif.pc), 64'(r.pc));
        check("head_nextpc", 64'(tif.nextpc), 64'(r.nextpc));
        check("head_inst", 64'(tif.inst), 64'(r.inst));
        if (m_have_last && r.pc != m_last_nextpc && !m_err) begin
          m_err = 1;
          m_err_pc = r.pc;
        end
        m_last_nextpc = r.nextpc;
        m_have_last = 1;
        m_pops++;
      end
      if (push) exp_q.push_back('{tif.wb_pc, tif.wb_nextpc, tif.wb_inst});
      m_count = m_count + int'(push) - int'(pop);
      m_pushed = push;
    end
  end

  // Holds the record until the model reports it accepted; returns 1 ns after the accepting edge.
  task automatic push_rec(input logic [31:0] pc, input logic [31:0] nextpc, input logic [31:0] inst);
    tif.wb_valid  = 1'b1;
    tif.wb_pc     = pc;
    tif.wb_nextpc = nextpc;
    tif.wb_inst   = inst;
    for (int c = 0; c < 64; c++) begin
      @(posedge clock);
      #1;
      if (m_pushed) begin
        tif.wb_valid = 1'b0;
        return;
      end
    end
    check("push_timeout", 64'd0, 64'd1);
    tif.wb_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 200; c++) begin
      @(posedge clock);
      #1;
      if (m_count == 0) return;
    end
    check("drain_timeout", 64'(m_count), 64'd0);
  endtask

  initial begin
    tif.wb_valid  = 1'b0;
    tif.wb_pc     = '0;
    tif.wb_nextpc = '0;
    tif.wb_inst   = '0;
    tif.out_ready = 1'b1;

    #2;
    check("rst_dpi_valid", 64'(tif.dpi_valid), 64'd0);
    check("rst_pc", 64'(tif.pc), 64'd0);
    check("rst_nextpc", 64'(tif.nextpc), 64'd0);
    check("rst_inst", 64'(tif.inst), 64'd0);
    check("rst_chain_err", 64'(tif.chain_err), 64'd0);
    check("rst_err_pc", 64'(tif.err_pc), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    check("rst_wb_ready", 64'(tif.wb_ready), 64'd1);

    // Single record from empty: visible one cycle after the push, gone the cycle after.
    push_rec(32'h8000_0000, 32'h8000_0004, 32'h0000_0013);
    check("t2_valid", 64'(tif.dpi_valid), 64'd1);
    check("t2_pc", 64'(tif.pc), 64'h8000_0000);
    @(posedge clock);
    #1 check("t2_empty", 64'(tif.dpi_valid), 64'd0);

    // Chain break at 0x80000010, second break at 0x80000020 must not move err_pc.
    push_rec(32'h8000_0010, 32'h8000_0014, 32'h0000_0093);
    push_rec(32'h8000_0014, 32'h8000_0018, 32'h0000_0113);
    push_rec(32'h8000_0020, 32'h8000_0024, 32'h0000_0193);
    wait_drain();
    check("t4_chain_err", 64'(tif.chain_err), 64'd1);
    check("t4_err_pc", 64'(tif.err_pc), 64'h8000_0010);

    // Fill with the consumer stalled; the 5th record waits for space.
    tif.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          push_rec(32'h0000_1000 + 32'(4*i), 32'h0000_1004 + 32'(4*i), 32'h00A0_0000 + 32'(i));
          if (i == 3) check("t3_full", 64'(tif.wb_ready), 64'd0);
        end
      end
      begin
        repeat (10) @(posedge clock);
        #1 tif.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Steady push and pop at occupancy 1; pointers wrap several times.
    for (int i = 0; i < 21; i++) begin
      push_rec(32'h0000_2000 + 32'(4*i), 32'h0000_2004 + 32'(4*i), 32'h00B0_0000 + 32'(i));
      check("t5_valid", 64'(tif.dpi_valid), 64'd1);
    end
    wait_drain();

    // Asynchronous reset with three records queued.
    tif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_rec(32'h0000_3000 + 32'(4*i), 32'h0000_3004 + 32'(4*i), 32'h00C0_0000 + 32'(i));
    #2 reset = 1'b0;
    #1;
    check("t1_dpi_valid", 64'(tif.dpi_valid), 64'd0);
    check("t1_chain_err", 64'(tif.chain_err), 64'd0);
    check("t1_err_pc", 64'(tif.err_pc), 64'd0);
    check("t1_wb_ready", 64'(tif.wb_ready), 64'd1);
`ifdef COMMIT_CNT_EN
    check("t1_commit_cnt", commit_cnt, 64'd0);
`endif
    @(posedge clock);
    #1 reset = 1'b1;
    tif.out_ready = 1'b1;

    // First record after reset is not chain-checked even though its pc is arbitrary.
    push_rec(32'hDEAD_0000, 32'hDEAD_0004, 32'h0000_0073);
    push_rec(32'hDEAD_0004, 32'hDEAD_0008, 32'h0000_00F3);
    wait_drain();
    check("post_rst_chain_err", 64'(tif.chain_err), 64'd0);
    check("post_rst_pops", m_pops, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
